midi_note_parser: RTL and testbench
===================================

Name: midi_note_parser

Overview:
Byte-level MIDI parser between the SPI slave's receive stream and the DDS voice core. It takes one byte per valid strobe and decodes Note On / Note Off messages, including running status and velocity-0 note-off. It emits a one-cycle note event and a held gate/note/velocity that drive phase-accumulator enable and note selection in the DDS. Non-note messages are length-tracked and discarded so that byte framing never slips.

Parameters:
OMNI, 1, 1 = accept all channels; 0 = accept only MIDI_CHANNEL
MIDI_CHANNEL, 0, 4-bit channel number, used when OMNI=0

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
byte_valid  in  1  one-cycle strobe: byte_data holds a received byte (from spi_slave stsourcevalid)
byte_data  in  8  received MIDI byte
event_valid  out  1  one-cycle pulse: a complete accepted note message was decoded
event_note_on  out  1  1 = note on, 0 = note off; qualified by event_valid
event_note  out  7  note number of the event
event_velocity  out  7  velocity of the event (0 for note-off)
gate  out  1  held note-on state
held_note  out  7  note currently sounding, or last note sounded
held_velocity  out  7  velocity of held_note
led  out  8  8'hFF while gate=1, else 8'h00

Behaviour:
- Reset (sync, priority over everything): state=IDLE, running status cleared. All outputs 0, including led=8'h00. A byte strobed in the reset cycle is dropped.
- Byte classes:
  - status = bit7=1
  - data = bit7=0
  - realtime = 8'hF8..8'hFF
  - system common = 8'hF0..8'hF7
- Realtime bytes: ignored entirely. No change to state, running status or data latches, so they can interleave inside a message.
- System common bytes: clear running status and go to IDLE. All data bytes are then discarded until the next channel status byte (SysEx payload is skipped this way).
- Channel status 8'h80..8'hEF:
  - Latch status as running status.
  - Latch msg_len: 2 for 8x, 9x, Ax, Bx, Ex; 1 for Cx, Dx.
  - Go to WAIT_D1.
  - A new status byte in any state aborts the partial message. It is never emitted.
- States:
  - IDLE: data bytes discarded.
  - WAIT_D1 + data: latch d1. If msg_len=1, message done and go to WAIT_D1 (running status). Otherwise go to WAIT_D2.
  - WAIT_D2 + data: latch d2, message done, go to WAIT_D1 (running status).
- Message done, accepted only if status is 8x or 9x and the channel passes the filter (OMNI=1, or status[3:0]==MIDI_CHANNEL):
  - event_valid=1 in the cycle after the completing byte_valid (latency 1).
  - event_note = d1[6:0].
  - event_note_on = (status[7:4]==9 && d2!=0).
  - event_velocity = d2[6:0] if note-on, else 0.
- Gate policy (last-note priority), updated in the same cycle as event_valid:
  - Note-on: gate=1; held_note=note; held_velocity=velocity.
  - Note-off with note==held_note: gate=0; held_note and held_velocity keep their values.
  - Note-off with note!=held_note: event still emitted; gate and held values unchanged.
- Any other completed message, or a filtered-out channel: no event, no gate change.
- event_valid is 0 in every other cycle. event_note, event_note_on and event_velocity hold their last values when event_valid=0.
- Back-to-back byte_valid on consecutive cycles must be handled with no loss. Maximum rate is one byte per clk.
- led is registered from gate, i.e. it tracks gate with the same timing.

Test Plan:
- Reset, then bytes 90 3C 64 -> event_valid pulse exactly 1 clk after the 64 strobe with note_on=1, note=3C, velocity=64; gate=1; held_note=3C; led=FF.
- Running status: 90 3C 64, 40 50, 3C 00 -> three events: (on,3C,64), (on,40,50), (off,3C,0). After the third event gate=1 and held_note=40, because 3C != held note.
- Note-off clears gate: 90 45 7F, 80 45 10 -> second event is off with velocity 0; gate=0; held_note stays 45; led=00.
- Interleave and abort: 90 F8 3C FE 64 -> single note-on event for 3C/64 (realtime ignored). Then 90 3C B0 07 7F -> no note event (partial message aborted; CC discarded). Then C0 05 -> no event, parser stays in WAIT_D1 (running status).
- SysEx skip and channel filter: F0 01 02 F7 3C 64 -> no events (running status cleared). With OMNI=0, MIDI_CHANNEL=2: 91 3C 64 gives no event, 92 3C 64 gives an event.
- Reset mid-message: 90 3C, assert reset 1 clk, then 64 -> no event, all outputs 0, state IDLE.

Source files
------------

// File: rtl/midi_note_parser.sv
// Byte-level MIDI Note On/Off decoder with running status, realtime pass-through
// and length tracking of non-note messages; drives a last-note-priority gate.
module midi_note_parser #(
    parameter bit         OMNI         = 1'b1,
    parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       event_valid,
    output logic       event_note_on,
    output logic [6:0] event_note,
    output logic [6:0] event_velocity,
    output logic       gate,
    output logic [6:0] held_note,
    output logic [6:0] held_velocity,
    output logic [7:0] led
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] status_q, status_d;
    logic       two_bytes_q, two_bytes_d;
    logic [6:0] d1_q, d1_d;

    logic       ev_valid_q, ev_valid_d;
    logic       ev_on_q, ev_on_d;
    logic [6:0] ev_note_q, ev_note_d;
    logic [6:0] ev_vel_q, ev_vel_d;
    logic       gate_q, gate_d;
    logic [6:0] held_note_q, held_note_d;
    logic [6:0] held_vel_q, held_vel_d;
    logic [7:0] led_q, led_d;

    logic       msg_done;
    logic       is_note_msg;
    logic       chan_ok;
    logic       note_on;

    // Only two-data-byte messages can be notes, so completion is tracked in WAIT_D2.
    assign is_note_msg = (status_q[7:5] == 3'b100);
    assign chan_ok     = OMNI || (status_q[3:0] == MIDI_CHANNEL);
    assign note_on     = status_q[4] && (byte_data[6:0] != 7'd0);

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        two_bytes_d = two_bytes_q;
        d1_d        = d1_q;
        ev_valid_d  = 1'b0;
        ev_on_d     = ev_on_q;
        ev_note_d   = ev_note_q;
        ev_vel_d    = ev_vel_q;
        gate_d      = gate_q;
        held_note_d = held_note_q;
        held_vel_d  = held_vel_q;
        msg_done    = 1'b0;

        if (byte_valid) begin
            if (byte_data[7]) begin
                if (byte_data[7:3] == 5'b11111) begin
                    // Realtime: transparent, may sit inside any message.
                end else if (byte_data[7:4] == 4'hF) begin
                    state_d  = ST_IDLE;
                    status_d = 8'h00;
                end else begin
                    status_d    = byte_data;
                    two_bytes_d = (byte_data[7:4] != 4'hC) && (byte_data[7:4] != 4'hD);
                    state_d     = ST_WAIT_D1;
                end
            end else begin
                case (state_q)
                    ST_WAIT_D1: begin
                        d1_d    = byte_data[6:0];
                        state_d = two_bytes_q ? ST_WAIT_D2 : ST_WAIT_D1;
                    end
                    ST_WAIT_D2: begin
                        msg_done = 1'b1;
                        state_d  = ST_WAIT_D1;
                    end
                    default: begin
                    end
                endcase
            end
        end

        if (msg_done && is_note_msg && chan_ok) begin
            ev_valid_d = 1'b1;
            ev_note_d  = d1_q;
            ev_on_d    = note_on;
            ev_vel_d   = note_on ? byte_data[6:0] : 7'd0;
            if (note_on) begin
                gate_d      = 1'b1;
                held_note_d = d1_q;
                held_vel_d  = byte_data[6:0];
            end else if (d1_q == held_note_q) begin
                gate_d = 1'b0;
            end
        end

        led_d = {8{gate_d}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            status_q    <= 8'h00;
            two_bytes_q <= 1'b0;
            d1_q        <= 7'd0;
            ev_valid_q  <= 1'b0;
            ev_on_q     <= 1'b0;
            ev_note_q   <= 7'd0;
            ev_vel_q    <= 7'd0;
            gate_q      <= 1'b0;
            held_note_q <= 7'd0;
            held_vel_q  <= 7'd0;
            led_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            two_bytes_q <= two_bytes_d;
            d1_q        <= d1_d;
            ev_valid_q  <= ev_valid_d;
            ev_on_q     <= ev_on_d;
            ev_note_q   <= ev_note_d;
            ev_vel_q    <= ev_vel_d;
            gate_q      <= gate_d;
            held_note_q <= held_note_d;
            held_vel_q  <= held_vel_d;
            led_q       <= led_d;
        end
    end

    assign event_valid    = ev_valid_q;
    assign event_note_on  = ev_on_q;
    assign event_note     = ev_note_q;
    assign event_velocity = ev_vel_q;
    assign gate           = gate_q;
    assign held_note      = held_note_q;
    assign held_velocity  = held_vel_q;
    assign led            = led_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// Bench for midi_note_parser: directed scenarios plus random byte streams checked
// against a message-level reference model, on an omni and a channel-2 instance.
module tb_midi_note_parser;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data  = 8'h00;

    logic       ev [2];
    logic       on [2];
    logic       gt [2];
    logic [6:0] nt [2];
    logic [6:0] vl [2];
    logic [6:0] hn [2];
    logic [6:0] hv [2];
    logic [7:0] ld [2];

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    midi_note_parser #(.OMNI(1'b1), .MIDI_CHANNEL(4'd0)) dut_omni (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .event_valid(ev[0]), .event_note_on(on[0]), .event_note(nt[0]),
        .event_velocity(vl[0]), .gate(gt[0]), .held_note(hn[0]),
        .held_velocity(hv[0]), .led(ld[0])
    );

    midi_note_parser #(.OMNI(1'b0), .MIDI_CHANNEL(4'd2)) dut_ch2 (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .event_valid(ev[1]), .event_note_on(on[1]), .event_note(nt[1]),
        .event_velocity(vl[1]), .gate(gt[1]), .held_note(hn[1]),
        .held_velocity(hv[1]), .led(ld[1])
    );

    // Reference model: running status, collected data bytes, expected length.
    int         m_rs   [2];
    int         m_need [2];
    int         m_cnt  [2];
    logic [7:0] m_buf  [2][2];
    logic       m_ev   [2];
    logic       m_on   [2];
    logic       m_gate [2];
    logic [6:0] m_note [2];
    logic [6:0] m_vel  [2];
    logic [6:0] m_hn   [2];
    logic [6:0] m_hv   [2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rs[k] = -1; m_need[k] = 0; m_cnt[k] = 0;
            m_ev[k] = 1'b0; m_on[k] = 1'b0; m_gate[k] = 1'b0;
            m_note[k] = 7'd0; m_vel[k] = 7'd0; m_hn[k] = 7'd0; m_hv[k] = 7'd0;
        end
    endfunction

    function automatic void model_byte(input int k, input logic [7:0] b);
        int hi;
        int ch;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            m_rs[k] = -1; m_cnt[k] = 0;
            return;
        end
        if (b >= 8'h80) begin
            m_rs[k]   = int'(b);
            m_cnt[k]  = 0;
            m_need[k] = (b[7:4] == 4'hC || b[7:4] == 4'hD) ? 1 : 2;
            return;
        end
        if (m_rs[k] < 0) return;
        m_buf[k][m_cnt[k]] = b;
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] < m_need[k]) return;
        m_cnt[k] = 0;
        hi = m_rs[k] / 16;
        ch = m_rs[k] % 16;
        if (hi != 8 && hi != 9) return;
        if (k == 1 && ch != 2) return;
        m_ev[k]   = 1'b1;
        m_note[k] = m_buf[k][0][6:0];
        m_on[k]   = (hi == 9) && (m_buf[k][1] != 8'h00);
        m_vel[k]  = m_on[k] ? m_buf[k][1][6:0] : 7'd0;
        if (m_on[k]) begin
            m_gate[k] = 1'b1; m_hn[k] = m_note[k]; m_hv[k] = m_vel[k];
        end else if (m_note[k] == m_hn[k]) begin
            m_gate[k] = 1'b0;
        end
    endfunction

    // Called at a negedge; drives one cycle of input and returns at the next negedge.
    task automatic send(input logic v, input logic [7:0] b, input logic r);
        reset = r; byte_valid = v; byte_data = b;
        @(posedge clk);
        for (int k = 0; k < 2; k++) m_ev[k] = 1'b0;
        if (r) model_reset();
        else if (v) for (int k = 0; k < 2; k++) model_byte(k, b);
        @(negedge clk);
        reset = 1'b0; byte_valid = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        send(1'b1, b, 1'b0);
    endtask

    task automatic idle();
        send(1'b0, 8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic do_reset();
        send(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset();
        put(8'h90); put(8'h3C); put(8'h64);
        send(1'b1, 8'h90, 1'b1);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({ev[k], on[k], nt[k], vl[k], gt[k], hn[k], hv[k], ld[k]} !== 38'd0) begin
                n_errs++;
                $display("FAIL reset_outputs dut%0d: got ev=%b on=%b n=%h v=%h g=%b hn=%h hv=%h led=%h, want all 0",
                         k, ev[k], on[k], nt[k], vl[k], gt[k], hn[k], hv[k], ld[k]);
            end
        end
        put(8'h3C); put(8'h64);
        n_checks++;
        if (ev[0] !== 1'b0) begin
            n_errs++;
            $display("FAIL reset_drops_strobe: got event_valid=%b, want 0", ev[0]);
        end
    endtask

    task automatic test_note_on();
        do_reset();
        put(8'h90); put(8'h3C);
        n_checks++;
        if (ev[0] !== 1'b0) begin
            n_errs++;
            $display("FAIL note_on_early: got event_valid=%b after 2nd byte, want 0", ev[0]);
        end
        put(8'h64);
        $display("tx note_on: 90 3C 64 -> ev=%b on=%b note=%h vel=%h", ev[0], on[0], nt[0], vl[0]);
        n_checks++;
        if ({ev[0], on[0], nt[0], vl[0], gt[0], hn[0], hv[0], ld[0]} !==
            {1'b1, 1'b1, 7'h3C, 7'h64, 1'b1, 7'h3C, 7'h64, 8'hFF}) begin
            n_errs++;
            $display("FAIL note_on_event: got ev=%b on=%b n=%h v=%h g=%b hn=%h hv=%h led=%h, want 1 1 3c 64 1 3c 64 ff",
                     ev[0], on[0], nt[0], vl[0], gt[0], hn[0], hv[0], ld[0]);
        end
        idle();
        n_checks++;
        if ({ev[0], on[0], nt[0], vl[0], ld[0]} !== {1'b0, 1'b1, 7'h3C, 7'h64, 8'hFF}) begin
            n_errs++;
            $display("FAIL note_on_pulse_hold: got ev=%b on=%b n=%h v=%h led=%h, want 0 1 3c 64 ff",
                     ev[0], on[0], nt[0], vl[0], ld[0]);
        end
    endtask

    task automatic test_running_status();
        logic [7:0]  seq   [7] = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h50, 8'h3C, 8'h00};
        logic        exp_v [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [14:0] exp_e [7] = '{15'd0, 15'd0, {1'b1, 7'h3C, 7'h64}, 15'd0,
                                   {1'b1, 7'h40, 7'h50}, 15'd0, {1'b0, 7'h3C, 7'h00}};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            put(seq[i]);
            n_checks++;
            if (ev[0] !== exp_v[i]) begin
                n_errs++;
                $display("FAIL running_status_valid byte %0d: got %b, want %b", i, ev[0], exp_v[i]);
            end
            if (exp_v[i]) begin
                $display("tx running_status: byte %0d -> on=%b note=%h vel=%h", i, on[0], nt[0], vl[0]);
                n_checks++;
                if ({on[0], nt[0], vl[0]} !== exp_e[i]) begin
                    n_errs++;
                    $display("FAIL running_status_event byte %0d: got %h, want %h", i, {on[0], nt[0], vl[0]}, exp_e[i]);
                end
            end
        end
        n_checks++;
        if ({gt[0], hn[0]} !== {1'b1, 7'h40}) begin
            n_errs++;
            $display("FAIL running_status_gate: got gate=%b held=%h, want 1 40", gt[0], hn[0]);
        end
    endtask

    task automatic test_note_off();
        do_reset();
        put(8'h90); put(8'h45); put(8'h7F);
        put(8'h80); put(8'h45); put(8'h10);
        $display("tx note_off: 80 45 10 -> ev=%b on=%b note=%h vel=%h", ev[0], on[0], nt[0], vl[0]);
        n_checks++;
        if ({ev[0], on[0], nt[0], vl[0], gt[0], hn[0], hv[0], ld[0]} !==
            {1'b1, 1'b0, 7'h45, 7'h00, 1'b0, 7'h45, 7'h7F, 8'h00}) begin
            n_errs++;
            $display("FAIL note_off_event: got ev=%b on=%b n=%h v=%h g=%b hn=%h hv=%h led=%h, want 1 0 45 00 0 45 7f 00",
                     ev[0], on[0], nt[0], vl[0], gt[0], hn[0], hv[0], ld[0]);
        end
    endtask

    task automatic test_interleave_abort();
        logic [7:0] seq   [12] = '{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64,
                                   8'h90, 8'h3C, 8'hB0, 8'h07, 8'h7F, 8'hC0, 8'h05};
        logic       exp_v [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            put(seq[i]);
            n_checks++;
            if (ev[0] !== exp_v[i]) begin
                n_errs++;
                $display("FAIL interleave_valid byte %0d (%h): got %b, want %b", i, seq[i], ev[0], exp_v[i]);
            end
            if (exp_v[i]) begin
                n_checks++;
                if ({on[0], nt[0], vl[0]} !== {1'b1, 7'h3C, 7'h64}) begin
                    n_errs++;
                    $display("FAIL interleave_event: got on=%b n=%h v=%h, want 1 3c 64", on[0], nt[0], vl[0]);
                end
            end
        end
    endtask

    task automatic test_sysex_filter();
        logic [7:0] sx [6] = '{8'hF0, 8'h01, 8'h02, 8'hF7, 8'h3C, 8'h64};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            put(sx[i]);
            n_checks++;
            if ({ev[0], ev[1]} !== 2'b00) begin
                n_errs++;
                $display("FAIL sysex_skip byte %0d: got ev=%b%b, want 00", i, ev[0], ev[1]);
            end
        end
        put(8'h91); put(8'h3C); put(8'h64);
        n_checks++;
        if ({ev[0], ev[1]} !== 2'b10) begin
            n_errs++;
            $display("FAIL filter_ch1: got omni=%b ch2=%b, want 1 0", ev[0], ev[1]);
        end
        put(8'h92); put(8'h3C); put(8'h64);
        $display("tx filter: 92 3C 64 -> ch2 ev=%b note=%h vel=%h", ev[1], nt[1], vl[1]);
        n_checks++;
        if ({ev[1], on[1], nt[1], vl[1], gt[1]} !== {1'b1, 1'b1, 7'h3C, 7'h64, 1'b1}) begin
            n_errs++;
            $display("FAIL filter_ch2: got ev=%b on=%b n=%h v=%h g=%b, want 1 1 3c 64 1",
                     ev[1], on[1], nt[1], vl[1], gt[1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        put(8'h90); put(8'h45); put(8'h20);
        put(8'h90); put(8'h3C);
        do_reset();
        n_checks++;
        if ({ev[0], gt[0], hn[0], hv[0], ld[0]} !== 23'd0) begin
            n_errs++;
            $display("FAIL reset_mid_outputs: got ev=%b g=%b hn=%h hv=%h led=%h, want all 0",
                     ev[0], gt[0], hn[0], hv[0], ld[0]);
        end
        put(8'h64);
        n_checks++;
        if ({ev[0], gt[0]} !== 2'b00) begin
            n_errs++;
            $display("FAIL reset_mid_no_event: got ev=%b gate=%b, want 0 0", ev[0], gt[0]);
        end
    endtask

    task automatic test_back_to_back_random();
        int         r;
        int         shown = 0;
        int         n_events = 0;
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10) begin
                idle();
            end else begin
                if (r < 15)      b = 8'hF8 + 8'($urandom_range(0, 7));
                else if (r < 17) b = 8'hF0 + 8'($urandom_range(0, 7));
                else if (r < 24) b = {4'($urandom_range(10, 14)), 4'($urandom_range(0, 3))};
                else if (r < 40) b = {3'b100, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3))};
                else if (r < 70) b = 8'h3C + 8'($urandom_range(0, 3));
                else if (r < 82) b = 8'h00;
                else             b = 8'($urandom_range(0, 127));
                put(b);
            end
            for (int k = 0; k < 2; k++) begin
                if (m_ev[k]) n_events++;
                n_checks++;
                if ({ev[k], on[k], nt[k], vl[k], gt[k], hn[k], hv[k], ld[k]} !==
                    {m_ev[k], m_on[k], m_note[k], m_vel[k], m_gate[k], m_hn[k], m_hv[k], {8{m_gate[k]}}}) begin
                    n_errs++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL random dut%0d cycle %0d: got ev=%b on=%b n=%h v=%h g=%b hn=%h hv=%h led=%h, want ev=%b on=%b n=%h v=%h g=%b hn=%h hv=%h",
                                 k, i, ev[k], on[k], nt[k], vl[k], gt[k], hn[k], hv[k], ld[k],
                                 m_ev[k], m_on[k], m_note[k], m_vel[k], m_gate[k], m_hn[k], m_hv[k]);
                    end
                end
            end
        end
        $display("tx random: 4000 cycles, %0d model events", n_events);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        test_reset();
        test_note_on();
        test_running_status();
        test_note_off();
        test_interleave_abort();
        test_sysex_filter();
        test_reset_mid();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
